// File: rtl/mips_multicycle_control_if.sv
// Bundle of the instruction/memory handshake inputs and the datapath control
// outputs exchanged between the multi-cycle control FSM and the datapath.
interface mips_multicycle_control_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [5:0]             opcode;
  logic                   mem_ready;
  logic                   PCWrite;
  logic                   PCWriteCond;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   MemtoReg;
  logic                   IRWrite;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [1:0]             ALUOp;
  logic [1:0]             PCSource;
  logic                   illegal_op;
  logic [3:0]             state;
  logic [COUNT_WIDTH-1:0] retired;

  // Datapath side: supplies opcode and memory status, consumes controls.
  modport master (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op,
           state, retired
  );

  // Control unit side.
  modport slave (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op,
           state, retired
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Control outputs are
// registered from the next-state decode so they line up with the state
// register; only the memory-ready driven fetch strobes and the illegal-opcode
// pulse depend combinationally on inputs.
module mips_multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mips_multicycle_control_if.slave    bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADDR   = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECUTE   = 4'd6,
    RCOMPLETE = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Moore control values for one state; unlisted fields stay 0.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      DECODE:    begin c.alu_src_b = 2'b11; end
      MEMADDR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMREAD:   begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
      MEMWB:     begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWRITE:  begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
      EXECUTE:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      RCOMPLETE: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      BRANCH:    begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_t                 state_r;
  state_t                 next_s;
  ctrl_t                  ctrl_r;
  logic [COUNT_WIDTH-1:0] retired_r;
  logic                   retire_s;
  logic                   illegal_s;
  logic                   fetch_s;

  // Next-state, retire and illegal-opcode decode.
  always_comb begin
    next_s    = FETCH;
    retire_s  = 1'b0;
    illegal_s = 1'b0;
    case (state_r)
      FETCH:    next_s = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_s = MEMADDR;
          OP_RTYPE:     next_s = EXECUTE;
          OP_BEQ:       next_s = BRANCH;
          OP_J:         next_s = JUMP;
          default: begin
            next_s    = FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      MEMADDR: begin
        if (bus.opcode == OP_LW) begin
          next_s = MEMREAD;
        end else if (bus.opcode == OP_SW) begin
          next_s = MEMWRITE;
        end else begin
          next_s = FETCH;
        end
      end
      MEMREAD:  next_s = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: begin
        next_s   = bus.mem_ready ? FETCH : MEMWRITE;
        retire_s = bus.mem_ready;
      end
      EXECUTE:  next_s = RCOMPLETE;
      MEMWB, RCOMPLETE, BRANCH, JUMP: begin
        next_s   = FETCH;
        retire_s = 1'b1;
      end
      default:  next_s = FETCH;
    endcase
  end

  // State register with registered control outputs and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FETCH;
      ctrl_r    <= decode_ctrl(FETCH);
      retired_r <= '0;
    end else begin
      state_r <= next_s;
      ctrl_r  <= decode_ctrl(next_s);
      if (retire_s) begin
        retired_r <= retired_r + COUNT_WIDTH'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Fetch strobes follow mem_ready and are held off while reset is asserted.
  assign fetch_s = (state_r == FETCH) && rst_n;

  assign bus.PCWrite     = ctrl_r.pc_write | (fetch_s & bus.mem_ready);
  assign bus.IRWrite     = fetch_s & bus.mem_ready;
  assign bus.PCWriteCond = ctrl_r.pc_write_cond;
  assign bus.IorD        = ctrl_r.ior_d;
  assign bus.MemRead     = ctrl_r.mem_read;
  assign bus.MemWrite    = ctrl_r.mem_write;
  assign bus.MemtoReg    = ctrl_r.mem_to_reg;
  assign bus.RegDst      = ctrl_r.reg_dst;
  assign bus.RegWrite    = ctrl_r.reg_write;
  assign bus.ALUSrcA     = ctrl_r.alu_src_a;
  assign bus.ALUSrcB     = ctrl_r.alu_src_b;
  assign bus.ALUOp       = ctrl_r.alu_op;
  assign bus.PCSource    = ctrl_r.pc_source;
  assign bus.illegal_op  = illegal_s & rst_n;
  assign bus.state       = state_r;
  assign bus.retired     = retired_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: directed scenarios plus
// randomized traffic checked against an instruction-path reference model.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mips_multicycle_control_if #(.COUNT_WIDTH(32)) bus ();

  mips_multicycle_control #(.COUNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: each instruction is a list of states it walks through.
  int          path[$];
  int          m_idx = 0;
  logic [31:0] m_retired = 32'd0;

  function automatic logic legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010;
  endfunction

  function automatic void load_path(input logic [5:0] op);
    case (op)
      6'b000000: path = '{0, 1, 6, 7};
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000100: path = '{0, 1, 8};
      6'b000010: path = '{0, 1, 9};
      default:   path = '{0, 1};
    endcase
  endfunction

  function automatic logic [3:0] exp_state();
    return (m_idx == 0) ? 4'd0 : 4'(path[m_idx]);
  endfunction

  // Expected control vector from the per-state output table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] s, input logic mr,
                                           input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, srca, ill;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, srca, ill} = 11'd0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      4'd0: begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd1: begin srcb = 2'b11; ill = !legal(op); end
      4'd2: begin srca = 1'b1; srcb = 2'b10; end
      4'd3: begin mrd = 1'b1; iord = 1'b1; end
      4'd4: begin rw = 1'b1; m2r = 1'b1; end
      4'd5: begin mwr = 1'b1; iord = 1'b1; end
      4'd6: begin srca = 1'b1; aop = 2'b10; end
      4'd7: begin rw = 1'b1; rdst = 1'b1; end
      4'd8: begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      4'd9: begin pcw = 1'b1; psrc = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, srca, srcb, aop, psrc, ill};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op};
  endfunction

  function automatic logic [52:0] exp_all();
    return {exp_state(), exp_ctrl(exp_state(), bus.mem_ready, bus.opcode), m_retired};
  endfunction

  function automatic logic [52:0] dut_all();
    return {bus.state, dut_vec(), bus.retired};
  endfunction

  task automatic set_inputs(input logic [5:0] op, input logic mr);
    bus.opcode    = op;
    bus.mem_ready = mr;
    #1;
  endtask

  // Clock edge plus model step; returns in the low phase of the clock.
  task automatic advance();
    logic [3:0] s;
    logic       mr;
    logic [5:0] op;
    s  = exp_state();
    mr = bus.mem_ready;
    op = bus.opcode;
    @(posedge clk);
    if (!((s == 4'd0 || s == 4'd3 || s == 4'd5) && !mr)) begin
      if (m_idx != 0 && m_idx == path.size() - 1) begin
        m_idx = 0;
        if (path.size() > 2) m_retired = m_retired + 32'd1;
      end else begin
        if (m_idx == 0) load_path(op);
        m_idx++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_all() !== {4'd0, exp_ctrl(4'd0, 1'b0, 6'd0), 32'd0}) begin
      errors++;
      $display("FAIL reset_values got %h exp %h", dut_all(), {4'd0, exp_ctrl(4'd0, 1'b0, 6'd0), 32'd0});
    end
    rst_n = 1'b1;
    m_idx = 0;
    m_retired = 32'd0;
  endtask

  task automatic test_rtype();
    int seq[5] = '{0, 1, 6, 7, 0};
    logic [31:0] r0 = m_retired;
    for (int i = 0; i < 5; i++) begin
      set_inputs(6'b000000, 1'b1);
      checks++;
      if (dut_all() !== exp_all() || bus.state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL rtype cyc %0d got %h exp %h", i, dut_all(), exp_all());
      end
      if (i < 4) advance();
    end
    checks++;
    if (bus.retired !== r0 + 32'd1) begin
      errors++;
      $display("FAIL rtype_retired got %0d exp %0d", bus.retired, r0 + 32'd1);
    end
  endtask

  task automatic test_lw_stall();
    int   seq[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
    logic mr[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      set_inputs(6'b100011, mr[i]);
      checks++;
      if (dut_all() !== exp_all() || bus.state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL lw_stall cyc %0d got %h exp %h", i, dut_all(), exp_all());
      end
      if (i < 7) advance();
    end
  endtask

  task automatic test_back_to_back();
    int   seq[11] = '{0, 1, 2, 5, 0, 1, 8, 0, 1, 9, 0};
    logic [31:0] r0 = m_retired;
    logic [5:0]  op;
    for (int i = 0; i < 11; i++) begin
      op = (i < 4) ? 6'b101011 : (i < 7) ? 6'b000100 : 6'b000010;
      set_inputs(op, 1'b1);
      checks++;
      if (dut_all() !== exp_all() || bus.state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %h exp %h", i, dut_all(), exp_all());
      end
      if (i < 10) advance();
    end
    checks++;
    if (bus.retired !== r0 + 32'd3) begin
      errors++;
      $display("FAIL b2b_retired got %0d exp %0d", bus.retired, r0 + 32'd3);
    end
  endtask

  task automatic test_illegal();
    int seq[3] = '{0, 1, 0};
    logic [31:0] r0 = m_retired;
    for (int i = 0; i < 3; i++) begin
      set_inputs(6'b111111, 1'b1);
      checks++;
      if (dut_all() !== exp_all() || bus.state !== 4'(seq[i]) ||
          bus.illegal_op !== (i == 1)) begin
        errors++;
        $display("FAIL illegal cyc %0d got %h exp %h", i, dut_all(), exp_all());
      end
      if (i < 2) advance();
    end
    checks++;
    if (bus.retired !== r0) begin
      errors++;
      $display("FAIL illegal_retired got %0d exp %0d", bus.retired, r0);
    end
  endtask

  task automatic test_fetch_stall();
    int   seq[8] = '{0, 0, 0, 0, 1, 6, 7, 0};
    logic mr[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      set_inputs(6'b000000, mr[i]);
      checks++;
      if (dut_all() !== exp_all() || bus.state !== 4'(seq[i]) ||
          (i < 4 && bus.IRWrite !== mr[i])) begin
        errors++;
        $display("FAIL fetch_stall cyc %0d got %h exp %h", i, dut_all(), exp_all());
      end
      if (i < 7) advance();
    end
  endtask

  task automatic test_random();
    logic [5:0] legal_ops[5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    logic [5:0] op = 6'd0;
    for (int i = 0; i < 600; i++) begin
      if (m_idx == 0) begin
        op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 4)];
      end
      set_inputs(op, $urandom_range(0, 3) != 0);
      checks++;
      if (dut_all() !== exp_all()) begin
        errors++;
        $display("FAIL random cyc %0d op %b got %h exp %h", i, op, dut_all(), exp_all());
      end
      advance();
    end
    for (int i = 0; i < 20 && m_idx != 0; i++) begin
      set_inputs(op, 1'b1);
      advance();
    end
    checks++;
    if (m_idx != 0 || bus.state !== 4'd0) begin
      errors++;
      $display("FAIL random_drain state %0d exp 0", bus.state);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10 && exp_state() != 4'd5; i++) begin
      set_inputs(6'b101011, 1'b1);
      advance();
    end
    set_inputs(6'b101011, 1'b0);
    checks++;
    if (bus.state !== 4'd5 || bus.MemWrite !== 1'b1 || m_retired == 32'd0) begin
      errors++;
      $display("FAIL memwrite_stall state %0d memwrite %b exp 5 1", bus.state, bus.MemWrite);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.state, bus.MemWrite, bus.retired} !== {4'd0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL async_reset state %0d memwrite %b retired %0d exp 0 0 0",
               bus.state, bus.MemWrite, bus.retired);
    end
    m_idx = 0;
    m_retired = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    set_inputs(6'b000010, 1'b1);
    checks++;
    if (dut_all() !== exp_all()) begin
      errors++;
      $display("FAIL post_reset got %h exp %h", dut_all(), exp_all());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_back_to_back();
    test_illegal();
    test_fetch_stall();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM for the multi-cycle MIPS datapath. It decodes the 6-bit instruction opcode held in the instruction register and steps each instruction through fetch, decode, execute, memory and writeback. In every state it drives the datapath mux selects, the write enables and the 2-bit `ALUOp` consumed by the ALU control unit. It stalls on a memory-ready handshake and counts retired instructions.

## Interface
Parameters:
- `COUNT_WIDTH`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction bits [31:26] from the IR; stable from DECODE until the next FETCH.
- `mem_ready`  in  1  memory access completes this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath controls.
- `ALUSrcB`  out  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- `ALUOp`  out  2  00 add, 01 subtract, 10 R-type (use funct).
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `state`  out  4  current state encoding, for debug.
- `retired`  out  COUNT_WIDTH  count of completed instructions.

## Operation
- Supported opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000010 j.
- States and encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RCOMPLETE=7, BRANCH=8, JUMP=9. Codes 10–15 are unused and go to FETCH on the next edge.
- Outputs are Moore, decoded from the state. Any signal not listed for a state is 0.
  - FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00, IorD=0. IRWrite=PCWrite=`mem_ready`.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMREAD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWRITE: MemWrite=1, IorD=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RCOMPLETE: RegWrite=1, RegDst=1, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
- Transitions:
  - FETCH→DECODE when `mem_ready`=1; otherwise hold.
  - DECODE: lw/sw→MEMADDR, R-type→EXECUTE, beq→BRANCH, j→JUMP. Any other opcode→FETCH, with `illegal_op`=1 for that cycle (Mealy). An illegal opcode does not increment `retired`.
  - MEMADDR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB on `mem_ready`; otherwise hold.
  - MEMWRITE→FETCH on `mem_ready`; otherwise hold.
  - EXECUTE→RCOMPLETE.
  - MEMWB, RCOMPLETE, BRANCH, JUMP→FETCH unconditionally.
- `retired` increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, RCOMPLETE, BRANCH or JUMP. It wraps modulo 2^COUNT_WIDTH.
- While `mem_ready`=0 in a wait state, the outputs hold their state values. MemWrite stays 1 for every cycle of a MEMWRITE stall.

## Timing
- Reset (rst_n=0, effective immediately without a clock): state=FETCH and `retired`=0. PCWrite, IRWrite, MemWrite, RegWrite and PCWriteCond are forced to 0, and so is `illegal_op`. The other outputs show the FETCH values.
- FETCH is the first state after reset release, and the first edge with `rst_n`=1 evaluates it normally.
- Reset asserted mid-instruction abandons the instruction with no retire.
- Latency with `mem_ready` tied to 1, counted in clocks from FETCH to the next FETCH:
  - lw: 5
  - sw: 4
  - R-type: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.
- `retired` updates on the same edge that enters FETCH. It is visible in the first FETCH cycle.

## Test plan
- Reset release with opcode=000000 and mem_ready=1 → state sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. `retired`=1 after the 4th edge.
- lw (100011) with mem_ready low for 2 cycles in MEMREAD → sequence 0,1,2,3,3,3,4,0. MemRead=IorD=1 for all three cycles in state 3. MemtoReg=1 in state 4.
- sw (101011), then beq (000100), then j (000010), back to back → states 0,1,2,5,0,1,8,0,1,9,0. PCWriteCond=1 with ALUOp=01 only in state 8. PCSource=10 in state 9. `retired`=3.
- opcode=111111 → DECODE pulses illegal_op=1 for one cycle, the next state is FETCH, and `retired` is unchanged.
- mem_ready=0 in FETCH for 3 cycles → IRWrite=PCWrite=0 for those cycles, then 1 in the cycle mem_ready=1, then DECODE.
- rst_n dropped asynchronously in MEMWRITE → state=0 and `retired`=0 immediately. MemWrite falls without waiting for a clock edge.
